// File: rtl/data_mem_sized_if.sv
// rtl/data_mem_sized_if.sv - request/response bus of the sized byte-addressed data memory
interface data_mem_sized_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] address;
    logic [XLEN-1:0]   wrt_data;
    logic              resp_valid;
    logic [XLEN-1:0]   read_data;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, address, wrt_data,
        input  req_ready, resp_valid, read_data, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, address, wrt_data,
        output req_ready, resp_valid, read_data, resp_err
    );
endinterface

// File: rtl/data_mem_sized.sv
// rtl/data_mem_sized.sv - byte-addressed MEM-stage data memory with sized access, faults and clear sweep
module data_mem_sized #(
    parameter int XLEN   = 64,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    data_mem_sized_if.slave  bus
);
    localparam int NL = XLEN / 8;
    localparam int LB = $clog2(NL);
    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * NL);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state;
    logic [IW-1:0]   cnt;
    logic [XLEN-1:0] mem [DEPTH];

    logic            accept;
    logic            misalign;
    logic            range_err;
    logic            size_err;
    logic            fault;
    logic [LB-1:0]   lane;
    logic [IW-1:0]   widx;
    logic [NL-1:0]   wmask;
    logic [XLEN-1:0] wdata_sh;
    logic [XLEN-1:0] rword;
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] ext_mask;
    logic [XLEN-1:0] load_val;
    logic            sign_bit;

    assign bus.req_ready = (state == RUN);
    assign accept        = bus.req_valid && bus.req_ready;
    assign lane          = bus.address[LB-1:0];
    assign widx          = bus.address[LB+IW-1:LB];

    always_comb begin
        misalign = 1'b0;
        case (bus.req_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = bus.address[0];
            2'd2:    misalign = |bus.address[1:0];
            default: misalign = |bus.address[2:0];
        endcase
    end

    // Every address bit takes part in the range check, so aliases above the array fault.
    assign range_err = ({1'b0, bus.address} >= MEM_BYTES);
    assign size_err  = (XLEN == 32) && (bus.req_size == 2'd3);
    assign fault     = misalign || range_err || size_err;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < NL; i++) begin
            wmask[i] = (i >= int'(lane)) && (i < int'(lane) + (1 << bus.req_size));
        end
    end

    assign wdata_sh = bus.wrt_data << {lane, 3'b000};
    assign rword    = mem[widx];
    assign rshift   = rword >> {lane, 3'b000};

    always_comb begin
        ext_mask = '1;
        sign_bit = rshift[XLEN-1];
        case (bus.req_size)
            2'd0: begin
                ext_mask = XLEN'(64'h0000_0000_0000_00FF);
                sign_bit = rshift[7];
            end
            2'd1: begin
                ext_mask = XLEN'(64'h0000_0000_0000_FFFF);
                sign_bit = rshift[15];
            end
            2'd2: begin
                ext_mask = XLEN'(64'h0000_0000_FFFF_FFFF);
                sign_bit = rshift[31];
            end
            default: begin
                ext_mask = '1;
                sign_bit = rshift[XLEN-1];
            end
        endcase
    end

    // A full-width access has an all-ones mask, so the extension choice has no effect there.
    assign load_val = bus.req_unsigned ? (rshift & ext_mask)
                                       : ((rshift & ext_mask) | (sign_bit ? ~ext_mask : '0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                mem[cnt] <= '0;
            end else if (accept && bus.req_write && !fault) begin
                for (int i = 0; i < NL; i++) begin
                    if (wmask[i]) begin
                        mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= INIT;
            cnt           <= '0;
            bus.resp_valid <= 1'b0;
            bus.read_data  <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            bus.resp_valid <= accept;
            bus.resp_err   <= accept && fault;
            bus.read_data  <= (accept && !bus.req_write && !fault) ? load_val : '0;
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
                if (cnt == IW'(DEPTH - 1)) begin
                    state <= RUN;
                end
            end
        end
    end
endmodule
